// File: rtl/ram_pkg.sv
// Shared types, default geometry and the lane parity helper for the RAM lane bank.
package ram_pkg;

   localparam int unsigned DEF_DATA_W   = 72;
   localparam int unsigned DEF_DEPTH    = 4;
   localparam int unsigned DEF_LANE_W   = 9;
   localparam int unsigned PARITY_MAX_W = 64;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   // Even parity: the stored bit makes the lane plus parity XOR to zero.
   function automatic logic lane_parity(input logic [PARITY_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Optional output register stages for read data, valid strobe and parity flags.
module ram_rd_pipe #(
   parameter int unsigned DATA_W = 72,
   parameter int unsigned LANES  = 8,
   parameter int unsigned STAGES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [LANES-1:0]  in_perr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] r_data,
   output logic [LANES-1:0]  rd_perr
);

   if (STAGES == 0) begin : g_bypass
      assign rd_valid = in_valid;
      assign r_data   = in_data;
      assign rd_perr  = in_perr;
   end else begin : g_reg
      logic [DATA_W-1:0] d_q [STAGES];
      logic [LANES-1:0]  p_q [STAGES];
      logic [STAGES-1:0] v_q;

      // Data and flags only advance with a valid result so r_data holds between reads.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
               d_q[i] <= '0;
               p_q[i] <= '0;
            end
         end else begin
            v_q[0] <= in_valid;
            if (in_valid) begin
               d_q[0] <= in_data;
               p_q[0] <= in_perr;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
               v_q[i] <= v_q[i-1];
               if (v_q[i-1]) begin
                  d_q[i] <= d_q[i-1];
                  p_q[i] <= p_q[i-1];
               end
            end
         end
      end

      assign rd_valid = v_q[STAGES-1];
      assign r_data   = d_q[STAGES-1];
      assign rd_perr  = p_q[STAGES-1];
   end

endmodule

// File: rtl/ram_lane_bank.sv
// Single-port RAM bank with lane write enables, clear sweep and read-valid strobe.
// Optional per-lane even parity storage/check when RAM_PARITY_EN is defined.
module ram_lane_bank
   import ram_pkg::*;
#(
   parameter  int unsigned DATA_W  = DEF_DATA_W,
   parameter  int unsigned DEPTH   = DEF_DEPTH,
   parameter  int unsigned LANE_W  = DEF_LANE_W,
   parameter  int unsigned OUT_REG = 0,
   localparam int unsigned LANES   = DATA_W / LANE_W,
   localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enb,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic [LANES-1:0]  be,
   input  logic              clr,
   output logic              rdy,
   output logic [DATA_W-1:0] r_data,
   output logic              rd_valid,
   output logic [LANES-1:0]  rd_perr
);

   if ((DATA_W % LANE_W) != 0) begin : g_bad_lane
      $error("ram_lane_bank: DATA_W must be a multiple of LANE_W");
   end
   if (LANE_W > PARITY_MAX_W) begin : g_bad_lane_w
      $error("ram_lane_bank: LANE_W exceeds parity helper width");
   end

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              accept_c, wr_ok_c, rd_ok_c;
   logic              rd_req_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [DATA_W-1:0] rd_word_c;
   logic [LANES-1:0]  perr_c;
   logic              rs_valid;
   logic [DATA_W-1:0] rs_data;
   logic [LANES-1:0]  rs_perr;

   logic [DATA_W-1:0] mem [DEPTH];
`ifdef RAM_PARITY_EN
   logic [LANES-1:0]  par [DEPTH];
   logic [LANES-1:0]  rd_par_c;
`endif

   // clr outranks any request presented in the same cycle.
   assign accept_c = (state_q == ST_IDLE) && enb && !clr;
   assign wr_ok_c  = accept_c && wr && ({1'b0, addr} < DEPTH_L);
   assign rd_ok_c  = {1'b0, rd_addr_q} < DEPTH_L;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         ST_CLEAR: begin
            if (clr) begin
               ptr_d = '0;
            end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            if (clr) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         ptr_q     <= '0;
         rdy       <= 1'b0;
         rd_req_q  <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         rdy      <= (state_d == ST_IDLE);
         rd_req_q <= accept_c && !wr;
         if (accept_c && !wr) rd_addr_q <= addr;
      end
   end

   // Storage: the clear sweep owns the array while it runs.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == ST_CLEAR) begin
            mem[ptr_q] <= '0;
`ifdef RAM_PARITY_EN
            for (int i = 0; i < int'(LANES); i++)
               par[ptr_q][i] <= lane_parity('0);
`endif
         end else if (wr_ok_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
               if (be[i]) begin
                  mem[addr][i*LANE_W +: LANE_W] <= data[i*LANE_W +: LANE_W];
`ifdef RAM_PARITY_EN
                  par[addr][i] <= lane_parity(PARITY_MAX_W'(data[i*LANE_W +: LANE_W]));
`endif
               end
            end
         end
      end
   end

   assign rd_word_c = rd_ok_c ? mem[rd_addr_q] : '0;

`ifdef RAM_PARITY_EN
   assign rd_par_c = rd_ok_c ? par[rd_addr_q] : '0;

   always_comb begin
      perr_c = '0;
      for (int i = 0; i < int'(LANES); i++)
         perr_c[i] = rd_par_c[i] ^ lane_parity(PARITY_MAX_W'(rd_word_c[i*LANE_W +: LANE_W]));
   end
`else
   assign perr_c = '0;
`endif

   // Array read stage: fires one edge after the request was sampled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rs_valid <= 1'b0;
         rs_data  <= '0;
         rs_perr  <= '0;
      end else begin
         rs_valid <= rd_req_q;
         if (rd_req_q) begin
            rs_data <= rd_word_c;
            rs_perr <= perr_c;
         end
      end
   end

   ram_rd_pipe #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .STAGES (OUT_REG)
   ) u_rd_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (rs_valid),
      .in_data  (rs_data),
      .in_perr  (rs_perr),
      .rd_valid (rd_valid),
      .r_data   (r_data),
      .rd_perr  (rd_perr)
   );

endmodule

// File: tb/tb_ram_lane_bank.sv
// Scoreboard bench for ram_lane_bank: OUT_REG=0 instance for the main tests, OUT_REG=1 for latency.
module tb_ram_lane_bank;

   typedef struct packed {
      logic [71:0] data;
      logic [7:0]  perr;
   } exp_t;

   logic        clk;
   logic        rst_n, enb, wr, clr;
   logic [1:0]  addr;
   logic [71:0] data;
   logic [7:0]  be;
   logic        rdy;
   logic [71:0] r_data;
   logic        rd_valid;
   logic [7:0]  rd_perr;

   logic        rst1_n, enb1;
   logic [1:0]  addr1;
   logic        wr1, clr1;
   logic [71:0] data1;
   logic [7:0]  be1;
   logic        rdy1;
   logic [71:0] r_data1;
   logic        rd_valid1;
   logic [7:0]  rd_perr1;

   exp_t exp0_q[$];
   exp_t exp1_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [7:0] perr_exp;

   ram_lane_bank #(.DATA_W(72), .DEPTH(4), .LANE_W(9), .OUT_REG(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .enb(enb), .wr(wr), .addr(addr), .data(data),
      .be(be), .clr(clr), .rdy(rdy), .r_data(r_data), .rd_valid(rd_valid),
      .rd_perr(rd_perr)
   );

   ram_lane_bank #(.DATA_W(72), .DEPTH(4), .LANE_W(9), .OUT_REG(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .enb(enb1), .wr(wr1), .addr(addr1), .data(data1),
      .be(be1), .clr(clr1), .rdy(rdy1), .r_data(r_data1), .rd_valid(rd_valid1),
      .rd_perr(rd_perr1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitors: pop the next expected read result whenever a bank strobes rd_valid.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (exp0_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd0_unexpected: got rd_valid=1 r_data=%h expected no read", r_data);
         end else begin
            exp_t e;
            e = exp0_q.pop_front();
            chk("rd0_data", r_data, e.data);
            chk("rd0_perr", 72'(rd_perr), 72'(e.perr));
         end
      end
   end

   always @(negedge clk) begin
      if (rd_valid1 === 1'b1) begin
         if (exp1_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd1_unexpected: got rd_valid=1 r_data=%h expected no read", r_data1);
         end else begin
            exp_t e;
            e = exp1_q.pop_front();
            chk("rd1_data", r_data1, e.data);
            chk("rd1_perr", 72'(rd_perr1), 72'(e.perr));
         end
      end
   end

   task automatic req(input logic w, input logic [1:0] a, input logic [71:0] d, input logic [7:0] b);
      enb = 1'b1; wr = w; addr = a; data = d; be = b;
      @(negedge clk);
      enb = 1'b0; wr = 1'b0;
   endtask

   task automatic rd0(input logic [1:0] a, input logic [71:0] d, input logic [7:0] p);
      exp0_q.push_back('{data: d, perr: p});
      req(1'b0, a, '0, '0);
   endtask

   task automatic rd1(input logic [1:0] a, input logic [71:0] d);
      exp1_q.push_back('{data: d, perr: 8'h00});
      enb1 = 1'b1; addr1 = a;
      @(negedge clk);
      enb1 = 1'b0;
   endtask

   task automatic idle(input int n);
      enb = 1'b0; wr = 1'b0; clr = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; enb = 1'b0; wr = 1'b0; clr = 1'b0; addr = '0; data = '0; be = '0;
      rst1_n = 1'b0; enb1 = 1'b0; wr1 = 1'b0; clr1 = 1'b0; addr1 = '0; data1 = '0; be1 = '0;
      repeat (2) @(negedge clk);

      // 1: reset state, clear sweep length, zeroed contents
      chk("reset_rdy", 72'(rdy), 72'(0));
      chk("reset_valid", 72'(rd_valid), 72'(0));
      chk("reset_rdata", r_data, 72'h0);
      chk("reset_perr", 72'(rd_perr), 72'(0));
      rst_n = 1'b1; rst1_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("clear_rdy_low_%0d", i), 72'(rdy), 72'(0));
         @(negedge clk);
      end
      chk("clear_rdy_high", 72'(rdy), 72'(1));
      for (int a = 0; a < 4; a++) rd0(2'(a), 72'h0, 8'h00);
      idle(3);

      // 2: write then read next cycle, check latency
      req(1'b1, 2'd3, 72'hAB_CDEF_0123_4567_89AB, 8'hFF);
      rd0(2'd3, 72'hAB_CDEF_0123_4567_89AB, 8'h00);
      chk("lat1_valid_early", 72'(rd_valid), 72'(0));
      @(negedge clk);
      chk("lat1_valid_on", 72'(rd_valid), 72'(1));
      idle(2);
      chk("rdata_hold", r_data, 72'hAB_CDEF_0123_4567_89AB);

      // 3: single-lane write
      req(1'b1, 2'd1, 72'hFF_FFFF_FFFF_FFFF_FFFF, 8'h01);
      rd0(2'd1, 72'h1FF, 8'h00);
      idle(3);

      // 4: clr beats a same-cycle read; requests during the sweep are dropped
      enb = 1'b1; wr = 1'b0; addr = 2'd3; clr = 1'b1;
      @(negedge clk);
      enb = 1'b0; clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("clr_rdy_low_%0d", i), 72'(rdy), 72'(0));
         chk($sformatf("clr_no_valid_%0d", i), 72'(rd_valid), 72'(0));
         if (i == 3) req(1'b1, 2'd0, 72'hFF_FFFF_FFFF_FFFF_FFFF, 8'hFF);
         else @(negedge clk);
      end
      chk("clr_rdy_high", 72'(rdy), 72'(1));
      rd0(2'd3, 72'h0, 8'h00);
      rd0(2'd0, 72'h0, 8'h00);
      idle(3);

      // be=0 no-op, then top and bottom lanes only
      req(1'b1, 2'd3, 72'hFF_FFFF_FFFF_FFFF_FFFF, 8'h00);
      rd0(2'd3, 72'h0, 8'h00);
      req(1'b1, 2'd3, 72'h12_3456_789A_BCDE_F012, 8'h81);
      rd0(2'd3, 72'h12_0000_0000_0000_0012, 8'h00);
      idle(3);

      // 5: corrupt a stored bit in lane 2 of address 2
`ifdef RAM_PARITY_EN
      perr_exp = 8'h04;
`else
      perr_exp = 8'h00;
`endif
      dut0.mem[2][20] = ~dut0.mem[2][20];
      rd0(2'd2, 72'h10_0000, perr_exp);
      idle(3);

      // 6: OUT_REG=1 burst latency
      rd1(2'd0, 72'h0);
      chk("lat2_valid_n0", 72'(rd_valid1), 72'(0));
      rd1(2'd1, 72'h0);
      chk("lat2_valid_n1", 72'(rd_valid1), 72'(0));
      rd1(2'd2, 72'h0);
      chk("lat2_valid_n2", 72'(rd_valid1), 72'(1));
      rd1(2'd3, 72'h0);
      chk("lat2_valid_n3", 72'(rd_valid1), 72'(1));
      @(negedge clk);
      chk("lat2_valid_n4", 72'(rd_valid1), 72'(1));
      @(negedge clk);
      chk("lat2_valid_n5", 72'(rd_valid1), 72'(1));
      @(negedge clk);
      chk("lat2_valid_n6", 72'(rd_valid1), 72'(0));

      // reset during a second burst flushes the in-flight reads
      for (int a = 0; a < 4; a++) rd1(2'(a), 72'h0);
      rst1_n = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 72'(rd_valid1), 72'(0));
      chk("midrst_rdata", r_data1, 72'h0);
      chk("midrst_rdy", 72'(rdy1), 72'(0));
      exp1_q.delete();
      @(negedge clk);
      chk("midrst_valid2", 72'(rd_valid1), 72'(0));
      rst1_n = 1'b1;
      repeat (6) @(negedge clk);

      chk("sb0_drained", 72'(exp0_q.size()), 72'(0));
      chk("sb1_drained", 72'(exp1_q.size()), 72'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
